// File: rtl/conv_engine.sv
// conv_engine: KxK stride-S valid 2-D convolution, weights/image read from M0, results written to M1.
// Optional build macro CONV_RELU_EN clamps negative saturated results to zero before the write.
module conv_engine #(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int KSIZE    = 3,
    parameter int STRIDE   = 1,
    parameter int SHIFT    = 0,
    parameter int WGT_BASE = 0,
    parameter int IMG_BASE = 64,
    parameter int OUT_BASE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        finish,
    output logic        busy,
    output logic        M0_R_req,
    output logic [31:0] M0_addr,
    input  logic [31:0] M0_R_data,
    output logic [3:0]  M0_W_req,
    output logic [31:0] M0_W_data,
    output logic        M1_R_req,
    output logic [31:0] M1_addr,
    input  logic [31:0] M1_R_data,
    output logic [3:0]  M1_W_req,
    output logic [31:0] M1_W_data
);
    localparam int KK    = KSIZE * KSIZE;
    localparam int CW    = $clog2(KK + 1);
    localparam int IW    = (KK > 1) ? $clog2(KK) : 1;
    localparam int AW    = 64 + $clog2(KK);
    localparam int OUT_W = (IMG_W - KSIZE) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - KSIZE) / STRIDE + 1;
    localparam logic [CW-1:0] KK_C = CW'(KK);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_CONV, S_WRITE, S_DONE} state_t;

    state_t               r_state, w_state_nx;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_widx;
    logic                 r_vld;
    logic [31:0]          r_kx, r_ky, r_ox, r_oy, r_addr_q;
    logic signed [31:0]   r_wgt [KK];
    logic signed [AW-1:0] r_acc, w_prod, w_sh;
    logic signed [31:0]   w_pix, w_wsel;
    logic [31:0]          w_rd_addr, w_sat, w_res;
    logic                 w_rd, w_last_px, w_hi_ok, w_unused;

    assign w_unused  = ^M1_R_data;
    assign w_pix     = M0_R_data;
    assign w_wsel    = r_wgt[r_widx];
    assign w_prod    = AW'(w_pix) * AW'(w_wsel);
    assign w_sh      = r_acc >>> SHIFT;
    assign w_hi_ok   = (&w_sh[AW-1:31]) | ~(|w_sh[AW-1:31]);
    assign w_sat     = w_hi_ok ? w_sh[31:0] : (w_sh[AW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF);
`ifdef CONV_RELU_EN
    assign w_res     = w_sat[31] ? 32'h0 : w_sat;
`else
    assign w_res     = w_sat;
`endif
    assign w_last_px = (r_ox == OUT_W - 1) && (r_oy == OUT_H - 1);
    assign w_rd      = (r_state == S_LOAD_W || r_state == S_CONV) && r_cnt != KK_C;
    assign w_rd_addr = (r_state == S_LOAD_W) ? WGT_BASE + 4 * 32'(r_cnt)
                     : IMG_BASE + 4 * ((r_oy * STRIDE + r_ky) * IMG_W + r_ox * STRIDE + r_kx);

    assign M0_R_req  = w_rd;
    assign M0_addr   = w_rd ? w_rd_addr : r_addr_q;
    assign M0_W_req  = 4'h0;
    assign M0_W_data = 32'h0;
    assign M1_R_req  = 1'b0;
    assign M1_addr   = OUT_BASE + 4 * (r_oy * OUT_W + r_ox);
    assign M1_W_data = w_res;

    // Next-state decode and state-derived status outputs.
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: w_state_nx = start ? S_LOAD_W : r_state;
            S_LOAD_W:       w_state_nx = (r_cnt == KK_C) ? S_CONV : S_LOAD_W;
            S_CONV:         w_state_nx = (r_cnt == KK_C) ? S_WRITE : S_CONV;
            S_WRITE:        w_state_nx = w_last_px ? S_DONE : S_CONV;
            default:        w_state_nx = S_IDLE;
        endcase
        busy     = (r_state == S_LOAD_W) || (r_state == S_CONV) || (r_state == S_WRITE);
        finish   = (r_state == S_DONE);
        M1_W_req = (r_state == S_WRITE) ? 4'hF : 4'h0;
    end

    // State, counters, weight file and accumulator; read data is consumed one cycle after its request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_widx   <= '0;
            r_vld    <= 1'b0;
            r_kx     <= '0;
            r_ky     <= '0;
            r_ox     <= '0;
            r_oy     <= '0;
            r_addr_q <= '0;
            r_acc    <= '0;
            for (int i = 0; i < KK; i++) r_wgt[i] <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_vld    <= w_rd;
            r_widx   <= r_cnt[IW-1:0];
            r_addr_q <= M0_addr;
            r_cnt    <= (w_state_nx != r_state) ? '0 : (w_rd ? r_cnt + CW'(1) : r_cnt);
            if (r_state != S_CONV) begin
                r_kx <= '0;
                r_ky <= '0;
            end else if (w_rd) begin
                r_kx <= (r_kx == KSIZE - 1) ? '0 : r_kx + 1;
                r_ky <= (r_kx == KSIZE - 1) ? ((r_ky == KSIZE - 1) ? '0 : r_ky + 1) : r_ky;
            end
            if (r_vld && r_state == S_LOAD_W) r_wgt[r_widx] <= w_pix;
            r_acc <= (w_state_nx == S_CONV && r_state != S_CONV) ? '0
                   : ((r_vld && r_state == S_CONV) ? r_acc + w_prod : r_acc);
            if (r_state == S_LOAD_W) begin
                r_ox <= '0;
                r_oy <= '0;
            end else if (r_state == S_WRITE) begin
                r_ox <= (r_ox == OUT_W - 1) ? '0 : r_ox + 1;
                r_oy <= (r_ox == OUT_W - 1) ? r_oy + 1 : r_oy;
            end
        end
    end
endmodule

// File: tb/tb_conv_engine.sv
// tb_conv_engine: directed scoreboard bench for conv_engine (default 8x8 instance and a 9x9 stride-2 instance).
module tb_conv_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_start = 1'b0, b_start = 1'b0;
    logic a_fin, a_busy, a_m0_req, a_m1_rreq, b_fin, b_busy, b_m0_req, b_m1_rreq;
    logic [31:0] a_m0_addr, a_m0_rd, a_m0_wd, a_m1_addr, a_m1_wd;
    logic [31:0] b_m0_addr, b_m0_rd, b_m0_wd, b_m1_addr, b_m1_wd;
    logic [3:0]  a_m0_wreq, a_m1_wreq, b_m0_wreq, b_m1_wreq;
    logic [31:0] m0 [128];
    logic [31:0] m1a [64];
    logic [31:0] m1b [64];
    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];
    int checks = 0, errors = 0, wcnt = 0;
`ifdef CONV_RELU_EN
    localparam logic [31:0] NEG_SAT = 32'h0000_0000;
    localparam logic [31:0] NEG9    = 32'h0000_0000;
`else
    localparam logic [31:0] NEG_SAT = 32'h8000_0000;
    localparam logic [31:0] NEG9    = 32'hFFFF_FFF7;
`endif

    always #5 clk = ~clk;

    conv_engine u_a (
        .clk(clk), .rst(rst), .start(a_start), .finish(a_fin), .busy(a_busy),
        .M0_R_req(a_m0_req), .M0_addr(a_m0_addr), .M0_R_data(a_m0_rd),
        .M0_W_req(a_m0_wreq), .M0_W_data(a_m0_wd), .M1_R_req(a_m1_rreq),
        .M1_addr(a_m1_addr), .M1_R_data(32'h0), .M1_W_req(a_m1_wreq), .M1_W_data(a_m1_wd)
    );

    conv_engine #(.IMG_W(9), .IMG_H(9), .STRIDE(2)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .finish(b_fin), .busy(b_busy),
        .M0_R_req(b_m0_req), .M0_addr(b_m0_addr), .M0_R_data(b_m0_rd),
        .M0_W_req(b_m0_wreq), .M0_W_data(b_m0_wd), .M1_R_req(b_m1_rreq),
        .M1_addr(b_m1_addr), .M1_R_data(32'h0), .M1_W_req(b_m1_wreq), .M1_W_data(b_m1_wd)
    );

    // M0 model: registered read, data valid the cycle after the request.
    always @(posedge clk) begin
        if (a_m0_req) a_m0_rd <= m0[a_m0_addr[8:2]];
        if (b_m0_req) b_m0_rd <= m0[b_m0_addr[8:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] addr, input logic [31:0] data);
        q_addr.push_back(addr);
        q_data.push_back(data);
    endtask

    task automatic mon(input int d, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data);
        wcnt++;
        chk("m1_wreq", {28'h0, we}, 32'hF);
        checks++;
        assert (q_addr.size() != 0) else begin
            errors++;
            $error("FAIL extra_write: got write addr %h data %h, expected none", addr, data);
        end
        if (q_addr.size() != 0) begin
            chk("m1_addr", addr, q_addr.pop_front());
            chk("m1_data", data, q_data.pop_front());
        end
        if (d == 0) m1a[addr[7:2]] = data;
        else m1b[addr[7:2]] = data;
    endtask

    always @(negedge clk) if (a_m1_wreq !== 4'h0) mon(0, a_m1_wreq, a_m1_addr, a_m1_wd);
    always @(negedge clk) if (b_m1_wreq !== 4'h0) mon(1, b_m1_wreq, b_m1_addr, b_m1_wd);

    function automatic logic fin_of(input int d);
        return (d == 0) ? a_fin : b_fin;
    endfunction

    function automatic logic busy_of(input int d);
        return (d == 0) ? a_busy : b_busy;
    endfunction

    task automatic set_start(input int d, input logic v);
        if (d == 0) a_start = v;
        else b_start = v;
    endtask

    task automatic fill(input int wv, input int pv, input int npix);
        for (int i = 0; i < 9; i++) m0[i] = wv;
        for (int i = 0; i < npix; i++) m0[16 + i] = pv;
    endtask

    task automatic push_const(input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) push(4 * i, v);
    endtask

    task automatic run(input int d, input int exp_n, input int pulse_at, input string tag);
        int n = 0;
        @(negedge clk);
        set_start(d, 1'b1);
        @(posedge clk);
        #1;
        set_start(d, 1'b0);
        chk({tag, "_busy"}, {31'h0, busy_of(d)}, 32'h1);
        chk({tag, "_fin_low"}, {31'h0, fin_of(d)}, 32'h0);
        while (n < 5000) begin
            @(posedge clk);
            #1;
            n++;
            set_start(d, n == pulse_at);
            if (fin_of(d)) break;
        end
        set_start(d, 1'b0);
        chk({tag, "_cycles"}, n, exp_n);
        chk({tag, "_pending"}, q_addr.size(), 0);
    endtask

    initial begin
        int n;
        int w0;
        for (int i = 0; i < 128; i++) m0[i] = '0;
        for (int i = 0; i < 64; i++) begin
            m1a[i] = '0;
            m1b[i] = '0;
        end
        m1b[16] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_finish", {31'h0, a_fin}, 32'h0);
        chk("rst_busy", {31'h0, a_busy}, 32'h0);
        chk("rst_m0_req", {31'h0, a_m0_req}, 32'h0);
        chk("rst_m0_addr", a_m0_addr, 32'h0);
        chk("rst_m0_wreq", {28'h0, a_m0_wreq}, 32'h0);
        chk("rst_m0_wdata", a_m0_wd, 32'h0);
        chk("rst_m1_rreq", {31'h0, a_m1_rreq}, 32'h0);
        chk("rst_m1_addr", a_m1_addr, 32'h0);
        chk("rst_m1_wreq", {28'h0, a_m1_wreq}, 32'h0);
        chk("rst_m1_wdata", a_m1_wd, 32'h0);
        chk("rst_b_finish", {31'h0, b_fin}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        fill(1, 1, 64);
        push_const(36, 32'd9);
        run(0, 406, 0, "ones");

        fill(0, 0, 64);
        m0[4] = 1;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) m0[16 + y * 8 + x] = y * 8 + x;
        for (int oy = 0; oy < 6; oy++)
            for (int ox = 0; ox < 6; ox++) push(4 * (oy * 6 + ox), (oy + 1) * 8 + ox + 1);
        run(0, 406, 0, "ident");

        fill(1, 32'h7FFF_FFFF, 64);
        push_const(36, 32'h7FFF_FFFF);
        run(0, 406, 0, "sat_pos");

        fill(-1, 32'h7FFF_FFFF, 64);
        push_const(36, NEG_SAT);
        run(0, 406, 0, "sat_neg");

        fill(-1, 1, 64);
        push_const(36, NEG9);
        run(0, 406, 0, "neg9");

        fill(1, 1, 64);
        push_const(36, 32'd9);
        run(0, 406, 20, "start_busy");
        push_const(36, 32'd9);
        run(0, 406, 0, "rerun_done");

        push_const(36, 32'd9);
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        w0 = wcnt;
        n = 0;
        while (wcnt - w0 < 10 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("abort_wr10", wcnt - w0, 10);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_addr.delete();
        q_data.delete();
        chk("abort_busy", {31'h0, a_busy}, 32'h0);
        chk("abort_fin", {31'h0, a_fin}, 32'h0);
        repeat (50) @(posedge clk);
        #1;
        chk("abort_nowr", wcnt - w0, 10);
        chk("abort_busy2", {31'h0, a_busy}, 32'h0);
        chk("abort_fin2", {31'h0, a_fin}, 32'h0);
        push_const(36, 32'd9);
        run(0, 406, 0, "after_abort");

        fill(1, 1, 81);
        push_const(16, 32'd9);
        run(1, 186, 0, "stride2");
        chk("stride2_untouched", m1b[16], 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
